bank_burst_sequencer: RTL and testbench

//  Upstream driver of Chip: accepts one burst request (bank group, bank, row, column, rd/wr, BL beats of data),

---
 rtl/dram_pkg.sv | 19 +
 rtl/rd_capture.sv | 47 ++++
 rtl/bank_burst_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_bank_burst_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and default geometry for the bank burst sequencer.
package dram_pkg;

    localparam int unsigned DEF_BGWIDTH   = 2;
    localparam int unsigned DEF_BAWIDTH   = 2;
    localparam int unsigned DEF_BL        = 8;
    localparam int unsigned BANKGROUPS    = 2 ** DEF_BGWIDTH;
    localparam int unsigned BANKSPERGROUP = 2 ** DEF_BAWIDTH;
    localparam int unsigned BEAT_IDX_W    = $clog2(DEF_BL);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        RESP
    } seq_state_t;

endpackage

// File: rtl/rd_capture.sv
// Delays (capture-enable, beat index) pairs so each read beat lands in its
// response slot exactly when the Chip returns it on dqout.
module rd_capture
    import dram_pkg::*;
#(
    parameter int unsigned Depth    = 1,
    parameter int unsigned IdxWidth = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_en_i,
    input  logic [IdxWidth-1:0] issue_idx_i,
    output logic                cap_en_o,
    output logic [IdxWidth-1:0] cap_idx_o
);

    logic [Depth-1:0]    en_q, en_d;
    logic [IdxWidth-1:0] idx_q [Depth];
    logic [IdxWidth-1:0] idx_d [Depth];

    // Shift the issue tag one stage per cycle.
    always_comb begin
        en_d[0]  = issue_en_i;
        idx_d[0] = issue_idx_i;
        for (int i = 1; i < int'(Depth); i++) begin
            en_d[i]  = en_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    // Pipeline registers; reset drops any in-flight capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            en_q  <= en_d;
            idx_q <= idx_d;
        end
    end

    assign cap_en_o  = en_q[Depth-1];
    assign cap_idx_o = idx_q[Depth-1];

endmodule

// File: rtl/bank_burst_sequencer.sv
// Expands one burst request into BL single-beat column accesses on one Chip
// bank and gathers read beats into a single BL-beat response.
module bank_burst_sequencer
    import dram_pkg::*;
#(
    parameter int unsigned BGWIDTH      = DEF_BGWIDTH,
    parameter int unsigned BAWIDTH      = DEF_BAWIDTH,
    parameter int unsigned COLWIDTH     = 10,
    parameter int unsigned CHWIDTH      = 5,
    parameter int unsigned DEVICE_WIDTH = 4,
    parameter int unsigned BL           = DEF_BL,
    parameter int unsigned RDLAT        = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [BGWIDTH-1:0]           req_bg,
    input  logic [BAWIDTH-1:0]           req_ba,
    input  logic [CHWIDTH-1:0]           req_row,
    input  logic [COLWIDTH-1:0]          req_col,
    input  logic [BL*DEVICE_WIDTH-1:0]   req_wdata,
    output logic                         wr_done,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [BL*DEVICE_WIDTH-1:0]   rsp_rdata,
    output logic [0:0]                   rd_o_wr [2**BGWIDTH][2**BAWIDTH],
    output logic [DEVICE_WIDTH-1:0]      dqin    [2**BGWIDTH][2**BAWIDTH],
    input  logic [DEVICE_WIDTH-1:0]      dqout   [2**BGWIDTH][2**BAWIDTH],
    output logic [CHWIDTH-1:0]           row     [2**BGWIDTH][2**BAWIDTH],
    output logic [COLWIDTH-1:0]          column  [2**BGWIDTH][2**BAWIDTH]
);

    localparam int unsigned NBG   = 2 ** BGWIDTH;
    localparam int unsigned NBA   = 2 ** BAWIDTH;
    localparam int unsigned DW    = DEVICE_WIDTH;
    localparam int unsigned IDXW  = $clog2(BL);
    localparam int unsigned BCW   = IDXW + 1;
    localparam int unsigned DRW   = $clog2(RDLAT + 1);
    localparam logic [COLWIDTH-1:0] BEAT_MASK = COLWIDTH'(BL - 1);

    seq_state_t                state_q, state_d;
    logic [BCW-1:0]            beat_q, beat_d;
    logic [DRW-1:0]            drain_q, drain_d;
    logic [BGWIDTH-1:0]        bg_q, bg_d;
    logic [BAWIDTH-1:0]        ba_q, ba_d;
    logic [CHWIDTH-1:0]        row_addr_q, row_addr_d;
    logic [COLWIDTH-1:0]       col_addr_q, col_addr_d;
    logic [BL*DW-1:0]          wdata_q, wdata_d;
    logic [BL*DW-1:0]          rdata_q, rdata_d;
    logic                      wr_done_q, wr_done_d;

    logic [0:0]                rd_o_wr_q [NBG][NBA];
    logic [0:0]                rd_o_wr_d [NBG][NBA];
    logic [DW-1:0]             dqin_q    [NBG][NBA];
    logic [DW-1:0]             dqin_d    [NBG][NBA];
    logic [CHWIDTH-1:0]        row_q     [NBG][NBA];
    logic [CHWIDTH-1:0]        row_d     [NBG][NBA];
    logic [COLWIDTH-1:0]       column_q  [NBG][NBA];
    logic [COLWIDTH-1:0]       column_d  [NBG][NBA];

    logic                      issue_en;
    logic                      cap_en;
    logic [IDXW-1:0]           cap_idx;
    logic [COLWIDTH-1:0]       beat_col;

    assign issue_en = (state_q == READ);

    rd_capture #(
        .Depth    (RDLAT),
        .IdxWidth (IDXW)
    ) u_rd_capture (
        .clk_i       (clk),
        .rst_i       (rst),
        .issue_en_i  (issue_en),
        .issue_idx_i (beat_q[IDXW-1:0]),
        .cap_en_o    (cap_en),
        .cap_idx_o   (cap_idx)
    );

    // Column of the beat about to be driven; wraps inside the BL-aligned block.
    assign beat_col = (col_addr_d & ~BEAT_MASK) |
                      ((col_addr_d + COLWIDTH'(beat_d)) & BEAT_MASK);

    // Sequencer FSM next state, request latching and read-slot capture.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        bg_d       = bg_q;
        ba_d       = ba_q;
        row_addr_d = row_addr_q;
        col_addr_d = col_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wr_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    bg_d       = req_bg;
                    ba_d       = req_ba;
                    row_addr_d = req_row;
                    col_addr_d = req_col;
                    wdata_d    = req_wdata;
                    beat_d     = '0;
                    state_d    = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (beat_q == BCW'(BL - 1)) begin
                    beat_d    = '0;
                    wr_done_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            READ: begin
                if (beat_q == BCW'(BL - 1)) begin
                    beat_d  = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRW'(RDLAT - 1)) begin
                    state_d = RESP;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Slot follows beat order, not column order.
        if (cap_en) begin
            rdata_d[int'(cap_idx) * DW +: DW] = dqout[bg_q][ba_q];
        end
    end

    // Chip port images for the next cycle: only the latched bank is ever nonzero.
    always_comb begin
        for (int g = 0; g < int'(NBG); g++) begin
            for (int b = 0; b < int'(NBA); b++) begin
                rd_o_wr_d[g][b] = '0;
                dqin_d[g][b]    = '0;
                row_d[g][b]     = '0;
                column_d[g][b]  = '0;
            end
        end
        if (state_d == WRITE || state_d == READ) begin
            rd_o_wr_d[bg_d][ba_d] = (state_d == WRITE);
            dqin_d[bg_d][ba_d]    = (state_d == WRITE) ?
                                    wdata_d[int'(beat_d[IDXW-1:0]) * DW +: DW] : '0;
            row_d[bg_d][ba_d]     = row_addr_d;
            column_d[bg_d][ba_d]  = beat_col;
        end
    end

    // State and registered Chip outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            drain_q    <= '0;
            bg_q       <= '0;
            ba_q       <= '0;
            row_addr_q <= '0;
            col_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wr_done_q  <= 1'b0;
            for (int g = 0; g < int'(NBG); g++) begin
                for (int b = 0; b < int'(NBA); b++) begin
                    rd_o_wr_q[g][b] <= '0;
                    dqin_q[g][b]    <= '0;
                    row_q[g][b]     <= '0;
                    column_q[g][b]  <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            drain_q    <= drain_d;
            bg_q       <= bg_d;
            ba_q       <= ba_d;
            row_addr_q <= row_addr_d;
            col_addr_q <= col_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wr_done_q  <= wr_done_d;
            rd_o_wr_q  <= rd_o_wr_d;
            dqin_q     <= dqin_d;
            row_q      <= row_d;
            column_q   <= column_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign wr_done   = wr_done_q;
    assign rd_o_wr   = rd_o_wr_q;
    assign dqin      = dqin_q;
    assign row       = row_q;
    assign column    = column_q;

endmodule

// File: tb/tb_bank_burst_sequencer.sv
// Randomized bench for bank_burst_sequencer with a behavioural Chip load and a
// transaction-level memory model.
module tb_bank_burst_sequencer;

    localparam int BGW = 2, BAW = 2, COLW = 10, CHW = 5, DW = 4, BL = 8, RDLAT = 1;
    localparam int NBG = 4, NBA = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid, req_ready, req_write;
    logic [BGW-1:0]     req_bg;
    logic [BAW-1:0]     req_ba;
    logic [CHW-1:0]     req_row;
    logic [COLW-1:0]    req_col;
    logic [BL*DW-1:0]   req_wdata;
    logic               wr_done, rsp_valid, rsp_ready;
    logic [BL*DW-1:0]   rsp_rdata;
    logic [0:0]         rd_o_wr [NBG][NBA];
    logic [DW-1:0]      dqin    [NBG][NBA];
    logic [DW-1:0]      dqout   [NBG][NBA];
    logic [CHW-1:0]     row     [NBG][NBA];
    logic [COLW-1:0]    column  [NBG][NBA];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] chip_mem [0:(1<<19)-1];
    logic [DW-1:0] ref_mem [int];

    always #5 clk = ~clk;

    bank_burst_sequencer #(
        .BGWIDTH(BGW), .BAWIDTH(BAW), .COLWIDTH(COLW), .CHWIDTH(CHW),
        .DEVICE_WIDTH(DW), .BL(BL), .RDLAT(RDLAT)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .req_col(req_col), .req_wdata(req_wdata), .wr_done(wr_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rd_o_wr(rd_o_wr), .dqin(dqin), .dqout(dqout), .row(row), .column(column)
    );

    function automatic int mem_key(int g, int b, int r, int c);
        return (g << 17) | (b << 15) | (r << 10) | c;
    endfunction

    // Chip load: writes when rd_o_wr is set, returns data one cycle later.
    always @(posedge clk) begin
        for (int g = 0; g < NBG; g++) begin
            for (int b = 0; b < NBA; b++) begin
                int k;
                k = mem_key(g, b, int'(row[g][b]), int'(column[g][b]));
                if (rd_o_wr[g][b][0]) chip_mem[k] <= dqin[g][b];
                dqout[g][b] <= chip_mem[k];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Beat k of a burst starting at col wraps inside the BL-aligned block.
    function automatic int exp_col(int col, int k);
        return (col / BL) * BL + ((col % BL) + k) % BL;
    endfunction

    function automatic logic [DW-1:0] ref_read(int key);
        return ref_mem.exists(key) ? ref_mem[key] : '0;
    endfunction

    // Number of banks other than (tg,tb) with any nonzero Chip output; tg=-1 means all.
    function automatic int active_elsewhere(int tg, int tb);
        int n = 0;
        for (int g = 0; g < NBG; g++) begin
            for (int b = 0; b < NBA; b++) begin
                if (!(g == tg && b == tb) &&
                    (rd_o_wr[g][b] != 0 || dqin[g][b] != 0 || row[g][b] != 0 || column[g][b] != 0))
                    n++;
            end
        end
        return n;
    endfunction

    task automatic scramble_req();
        req_write = 1'($urandom);
        req_bg    = BGW'($urandom);
        req_ba    = BAW'($urandom);
        req_row   = CHW'($urandom);
        req_col   = COLW'($urandom);
        req_wdata = {$urandom};
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first beat cycle.
    task automatic present(input bit wr, input int bg, input int ba, input int r, input int c,
                           input logic [BL*DW-1:0] data);
        check("req_ready_before_accept", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_bg    = BGW'(bg);
        req_ba    = BAW'(ba);
        req_row   = CHW'(r);
        req_col   = COLW'(c);
        req_wdata = data;
        @(negedge clk);
        req_valid = 1'b0;
        scramble_req();
    endtask

    task automatic do_write(input int bg, input int ba, input int r, input int c,
                            input logic [BL*DW-1:0] data, input int abort_at);
        present(1'b1, bg, ba, r, c, data);
        for (int k = 0; k < BL; k++) begin
            check("wr_rd_o_wr", rd_o_wr[bg][ba], 1);
            check("wr_column", column[bg][ba], exp_col(c, k));
            check("wr_row", row[bg][ba], r);
            check("wr_dqin", dqin[bg][ba], data[k*DW +: DW]);
            check("wr_other_banks", active_elsewhere(bg, ba), 0);
            check("wr_done_early", wr_done, 0);
            check("wr_req_ready_busy", req_ready, 0);
            // Busy-time requests must be ignored; drop them before IDLE returns.
            req_valid = (k < BL - 1 && abort_at < 0) ? 1'($urandom) : 1'b0;
            if (k == abort_at) begin
                for (int j = 0; j <= k; j++) ref_mem[mem_key(bg, ba, r, exp_col(c, j))] = data[j*DW +: DW];
                rst = 1'b1;
                @(negedge clk);
                check("abort_outputs_zero", active_elsewhere(-1, -1), 0);
                check("abort_no_wr_done", wr_done, 0);
                check("abort_req_ready", req_ready, 1);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check("abort_no_wr_done_after", wr_done, 0);
                check("abort_req_ready_after", req_ready, 1);
                return;
            end
            @(negedge clk);
        end
        check("wr_done_pulse", wr_done, 1);
        check("wr_outputs_zero_after", active_elsewhere(-1, -1), 0);
        check("wr_req_ready_after", req_ready, 1);
        for (int j = 0; j < BL; j++) ref_mem[mem_key(bg, ba, r, exp_col(c, j))] = data[j*DW +: DW];
    endtask

    task automatic do_read(input int bg, input int ba, input int r, input int c,
                           input int hold, input bit noise);
        logic [BL*DW-1:0] exp_rd;
        for (int k = 0; k < BL; k++) exp_rd[k*DW +: DW] = ref_read(mem_key(bg, ba, r, exp_col(c, k)));
        present(1'b0, bg, ba, r, c, {$urandom});
        for (int k = 0; k < BL; k++) begin
            check("rd_rd_o_wr", rd_o_wr[bg][ba], 0);
            check("rd_column", column[bg][ba], exp_col(c, k));
            check("rd_row", row[bg][ba], r);
            check("rd_dqin_zero", dqin[bg][ba], 0);
            check("rd_other_banks", active_elsewhere(bg, ba), 0);
            check("rd_rsp_valid_early", rsp_valid, 0);
            req_valid = (k < BL - 1) ? 1'($urandom) : 1'b0;
            rsp_ready = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        for (int d = 0; d < RDLAT; d++) begin
            check("drain_rsp_valid", rsp_valid, 0);
            check("drain_outputs_zero", active_elsewhere(-1, -1), 0);
            @(negedge clk);
        end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_req_ready", req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_rdata", rsp_rdata, exp_rd);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_cleared", rsp_valid, 0);
        check("req_ready_after_rsp", req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BL*DW-1:0] d;
        for (int i = 0; i < (1 << 19); i++) chip_mem[i] = '0;
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        scramble_req();
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_wr_done", wr_done, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_chip_ports", active_elsewhere(-1, -1), 0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned burst, then read it back.
        d = {$urandom};
        do_write(1, 1, 1, 0, d, -1);
        do_read(1, 1, 1, 0, 0, 1'b0);

        // Wrapping burst: slot 0 must hold the beat written to column 13.
        d = {$urandom};
        do_write(2, 3, 7, 13, d, -1);
        do_read(2, 3, 7, 13, 0, 1'b1);
        check("wrap_col13_value", ref_read(mem_key(2, 3, 7, 13)), d[DW-1:0]);

        // Consumer backpressure.
        do_read(1, 1, 1, 0, 10, 1'b0);

        // Reset during beat 3 leaves columns 4..7 with their previous contents.
        do_write(0, 2, 3, 0, {$urandom}, -1);
        do_write(0, 2, 3, 0, {$urandom}, 3);
        do_read(0, 2, 3, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int bg = $urandom_range(NBG - 1);
            int ba = $urandom_range(NBA - 1);
            int r  = $urandom_range(3);
            int c  = $urandom_range((1 << COLW) - 1);
            if ($urandom_range(1) == 1) begin
                int ab = ($urandom_range(7) == 0) ? $urandom_range(BL - 1) : -1;
                do_write(bg, ba, r, c, {$urandom}, ab);
            end else begin
                do_read(bg, ba, r, c, $urandom_range(3), 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
